// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - call/return address stack feeding topStack of the PC stage
// Optional sticky overflow/underflow flags are built only when RAS_ERROR_FLAGS_EN is defined.
module return_address_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EN,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topStack,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   sp;
  logic [PTR_W:0]   sp_dec;
  logic [PTR_W:0]   wr_ptr;
  logic             wr_en;

  assign sp_dec   = sp - ONE;
  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == FULL_CNT);
  assign topStack = empty ? '0 : mem[sp_dec[PTR_W-1:0]];

  // push+pop on a live top replaces it in place; otherwise a push lands above the top
  assign wr_ptr = (pop && !empty) ? sp_dec : sp;
  assign wr_en  = EN && !reset && push && ((pop && !empty) || !full);

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_ptr[PTR_W-1:0]] <= pushData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (EN) begin
      case ({push, pop})
        2'b10:   if (!full)  sp <= sp + ONE;
        2'b01:   if (!empty) sp <= sp_dec;
        2'b11:   if (empty)  sp <= ONE;
        default: sp <= sp;
      endcase
    end
  end

`ifdef RAS_ERROR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (EN) begin
      if (push && !pop && full)
        ovf_q <= 1'b1;
      if (pop && empty)
        unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed and randomized check of return_address_stack against a queue model
module tb_return_address_stack;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
`ifdef RAS_ERROR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             EN;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] pushData;
  logic [WIDTH-1:0] topStack;
  logic [4:0]       count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] stk[$];
  bit               m_ovf;
  bit               m_unf;

  always #5 clock = ~clock;

  return_address_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .EN(EN), .push(push), .pop(pop),
    .pushData(pushData), .topStack(topStack), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: a bounded LIFO of return addresses
  task automatic model_update(input bit r, input bit e, input bit pu, input bit po,
                              input logic [WIDTH-1:0] d);
    if (r) begin
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (e) begin
      if (pu && po) begin
        if (stk.size() == 0) begin
          stk.push_back(d);
          m_unf = 1'b1;
        end else begin
          stk[stk.size()-1] = d;
        end
      end else if (pu) begin
        if (stk.size() < DEPTH) stk.push_back(d);
        else m_ovf = 1'b1;
      end else if (po) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_unf = 1'b1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_top;
    exp_top = (stk.size() == 0) ? 32'h0 : stk[stk.size()-1];
    check({tag, ".top"}, topStack, exp_top);
    check({tag, ".count"}, 32'(count), 32'(stk.size()));
    check({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(stk.size() == DEPTH));
    check({tag, ".ovf"}, 32'(overflow), 32'(FLAGS & m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(FLAGS & m_unf));
  endtask

  task automatic step(input bit r, input bit e, input bit pu, input bit po,
                      input logic [WIDTH-1:0] d);
    @(negedge clock);
    reset = r; EN = e; push = pu; pop = po; pushData = d;
    @(posedge clock);
    model_update(r, e, pu, po, d);
    #1;
  endtask

  initial begin
    int phase;
    int pr;
    reset = 1'b1; EN = 1'b0; push = 1'b0; pop = 1'b0; pushData = '0;
    m_ovf = 1'b0; m_unf = 1'b0;

    // 1: reset then idle
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_state("t1");
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_top", topStack, 32'h0);

    // 2: three pushes then three pops
    step(0, 1, 1, 0, 32'h10); check("t2_top0", topStack, 32'h10);
    step(0, 1, 1, 0, 32'h20); check("t2_top1", topStack, 32'h20);
    step(0, 1, 1, 0, 32'h30); check("t2_top2", topStack, 32'h30);
    check("t2_count", 32'(count), 32'd3);
    step(0, 1, 0, 1, 0); check("t2_pop0", topStack, 32'h20);
    step(0, 1, 0, 1, 0); check("t2_pop1", topStack, 32'h10);
    step(0, 1, 0, 1, 0); check("t2_pop2", topStack, 32'h0);
    check("t2_empty", 32'(empty), 32'd1);
    check_state("t2");

    // 3: fill to DEPTH, then push once more
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 1, 0, 32'(i));
    check("t3_full", 32'(full), 32'd1);
    check("t3_top", topStack, 32'd16);
    step(0, 1, 1, 0, 32'h99);
    check("t3_count", 32'(count), 32'd16);
    check("t3_top_after", topStack, 32'd16);
    check("t3_ovf", 32'(overflow), 32'(FLAGS));
    check_state("t3");

    // 4: pop while empty, push+pop while empty
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    check("t4_count", 32'(count), 32'd0);
    check("t4_unf", 32'(underflow), 32'(FLAGS));
    step(0, 1, 1, 1, 32'h44);
    check("t4_pp_count", 32'(count), 32'd1);
    check("t4_pp_top", topStack, 32'h44);
    check_state("t4");

    // 5: replace top, then EN=0 hold, then confirm entry below survived
    step(0, 1, 1, 0, 32'hA0);
    step(0, 1, 1, 1, 32'hB0);
    check("t5_count", 32'(count), 32'd2);
    check("t5_top", topStack, 32'hB0);
    step(0, 0, 1, 0, 32'hC0);
    check("t5_hold_count", 32'(count), 32'd2);
    check("t5_hold_top", topStack, 32'hB0);
    step(0, 1, 0, 1, 0);
    check("t5_below", topStack, 32'h44);
    check_state("t5");

    // 6: reset wins over a simultaneous push
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h5);
    step(1, 1, 1, 0, 32'h5);
    check("t6_count", 32'(count), 32'd0);
    check("t6_top", topStack, 32'h0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_unf", 32'(underflow), 32'd0);

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 3000; i++) begin
      phase = (i / 150) % 2;
      pr = (phase == 0) ? 70 : 30;
      step(($urandom % 100) < 1,
           ($urandom % 8) != 0,
           ($urandom % 100) < pr,
           ($urandom % 100) < (100 - pr),
           $urandom);
      check_state("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
